// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned QDEPTH = 2;
    localparam int unsigned CNTW   = $clog2(QDEPTH + 1);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [CNTW-1:0] QFULL   = CNTW'(QDEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrop
    } fetch_state_e;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory request/ready handshake between the fetch sequencer and memory.
interface fetch_controller_if;
    import fetch_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic [XLEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry {instr, pc} FIFO feeding the IF/ID boundary; clear wins over push and pop.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] push_instr,
    input  logic [XLEN-1:0] push_pc,
    output logic [CNTW-1:0] count,
    output logic [XLEN-1:0] head_instr,
    output logic [XLEN-1:0] head_pc
);

    logic [XLEN-1:0] instr_mem [QDEPTH];
    logic [XLEN-1:0] pc_mem    [QDEPTH];
    logic            wr_ptr;
    logic            rd_ptr;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        do_push = push && (count != QFULL);
        do_pop  = pop && (count != '0);
    end

    // Depth is fixed at two, so the pointers are single toggling bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                instr_mem[wr_ptr] <= push_instr;
                pc_mem[wr_ptr]    <= push_pc;
                wr_ptr            <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    always_comb begin
        head_instr = instr_mem[rd_ptr];
        head_pc    = pc_mem[rd_ptr];
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, runs the imem handshake, buffers two instructions.
// Optional memory-timeout flag is built only when FETCH_TIMEOUT_EN is defined.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int unsigned     TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hazard_freeze,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    branch_addr,
    fetch_controller_if.master imem,
    output logic [XLEN-1:0]    instr,
    output logic [XLEN-1:0]    instr_pc,
    output logic               instr_valid,
    output logic               flush,
    output logic               fetch_err
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] addr_q;
    logic            req_q;
    logic            flush_q;
    logic            done;
    logic            q_push;
    logic            q_pop;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_next;

    always_comb begin
        done       = req_q && imem.ready;
        q_push     = (state_q == StFetch) && done && !branch_taken;
        q_pop      = instr_valid && !hazard_freeze && !branch_taken;
        count_next = branch_taken ? '0 : count + CNTW'(q_push) - CNTW'(q_pop);
        if (branch_taken) begin
            pc_d = branch_addr;
        end else if (q_push) begin
            pc_d = pc_q + PC_STEP;
        end else begin
            pc_d = pc_q;
        end
    end

    // A started request keeps req/addr frozen until ready; a new one starts only with room left.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= branch_taken;
            pc_q    <= pc_d;
            unique case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                    req_q   <= 1'b1;
                    addr_q  <= pc_d;
                end
                StFetch: begin
                    if (req_q && !imem.ready) begin
                        if (branch_taken) begin
                            state_q <= StDrop;
                        end
                    end else begin
                        req_q  <= (count_next != QFULL);
                        addr_q <= pc_d;
                    end
                end
                StDrop: begin
                    if (imem.ready) begin
                        state_q <= StFetch;
                        req_q   <= 1'b1;
                        addr_q  <= pc_d;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .pop        (q_pop),
        .clear      (branch_taken),
        .push_instr (imem.rdata),
        .push_pc    (pc_q),
        .count      (count),
        .head_instr (instr),
        .head_pc    (instr_pc)
    );

    assign imem.req    = req_q;
    assign imem.addr   = addr_q;
    assign instr_valid = (count != '0);
    assign flush       = flush_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wait_q;
    logic          err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else if (req_q && !imem.ready) begin
            if (wait_q != WW'(TIMEOUT_CYCLES)) begin
                wait_q <= wait_q + WW'(1);
            end
            if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
                err_q <= 1'b1;
            end
        end else begin
            wait_q <= '0;
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed and randomized bench for fetch_controller against a queue-based reference model.
module tb_fetch_controller;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0;
    localparam int          TO     = 16;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hazard_freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        flush;
    logic        fetch_err;

    fetch_controller_if imem_bus ();

    fetch_controller #(
        .RESET_PC       (RST_PC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hazard_freeze (hazard_freeze),
        .branch_taken  (branch_taken),
        .branch_addr   (branch_addr),
        .imem          (imem_bus),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .flush         (flush),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pc, outstanding request, drop flag, and the buffered {instr, pc} entries.
    bit          m_up;
    bit          m_out;
    bit          m_drop;
    bit          m_flush;
    bit          m_err;
    int          m_wait;
    logic [31:0] m_pc;
    logic [31:0] m_oaddr;
    logic [63:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_up = 0; m_out = 0; m_drop = 0; m_flush = 0; m_err = 0; m_wait = 0;
        m_pc = RST_PC; m_oaddr = RST_PC;
        m_q.delete();
    endtask

    task automatic model_edge(input bit fz, input bit br, input logic [31:0] ba,
                              input bit rdy, input logic [31:0] rd);
        bit pop;
        bit comp;
        pop  = (m_q.size() != 0) && !fz;
        comp = m_out && rdy;
        if (TO_EN) begin
            if (m_out && !rdy) begin
                m_wait++;
                if (m_wait >= TO) m_err = 1;
            end else begin
                m_wait = 0;
            end
        end
        m_flush = br;
        if (!m_up) begin
            m_up = 1;
            if (br) m_pc = ba;
            m_out   = 1;
            m_oaddr = m_pc;
        end else if (br) begin
            m_q.delete();
            if (m_out && !rdy) begin
                m_drop = 1;
            end else begin
                m_drop  = 0;
                m_out   = 1;
                m_oaddr = ba;
            end
            m_pc = ba;
        end else begin
            if (comp && !m_drop) begin
                m_q.push_back({rd, m_pc});
                m_pc = m_pc + 32'd4;
            end
            if (comp) m_drop = 0;
            if (pop) void'(m_q.pop_front());
            if (!m_out || comp) begin
                m_out   = (m_q.size() < 2);
                m_oaddr = m_pc;
            end
        end
    endtask

    task automatic check_outputs();
        logic [63:0] head;
        chk("imem_req", 32'(imem_bus.req), 32'(m_out));
        chk("imem_addr", imem_bus.addr, m_out ? m_oaddr : m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
        chk("flush", 32'(flush), 32'(m_flush));
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
        if (m_q.size() != 0) begin
            head = m_q[0];
            chk("instr", instr, head[63:32]);
            chk("instr_pc", instr_pc, head[31:0]);
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model at the rising edge, check after.
    task automatic step(input bit fz, input bit br, input logic [31:0] ba, input bit rdy);
        logic [31:0] rd;
        rd = $urandom;
        hazard_freeze  = fz;
        branch_taken   = br;
        branch_addr    = ba;
        imem_bus.ready = rdy;
        imem_bus.rdata = rd;
        @(posedge clk);
        model_edge(fz, br, ba, rdy, rd);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] ba;
        imem_bus.ready = 1'b0;
        imem_bus.rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_bus.req), 32'd0);
        chk("rst_addr", imem_bus.addr, RST_PC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        rst = 1'b1;
        check_outputs();

        // Zero-wait start-up and back-to-back addresses.
        step(0, 0, 0, 1);
        chk("first_req", 32'(imem_bus.req), 32'd1);
        chk("first_addr", imem_bus.addr, 32'd0);
        chk("valid_early", 32'(instr_valid), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 1);
            chk("seq_addr", imem_bus.addr, 32'(4 * k));
            if (k == 1) chk("valid_rise", 32'(instr_valid), 32'd1);
        end

        // Three wait states on address 12.
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            chk("hold_req", 32'(imem_bus.req), 32'd1);
            chk("hold_addr", imem_bus.addr, 32'd12);
        end
        step(0, 0, 0, 1);
        chk("late_pc", instr_pc, 32'd12);

        // Freeze fills the queue and stalls requests.
        for (int k = 0; k < 5; k++) step(1, 0, 0, 1);
        chk("freeze_req", 32'(imem_bus.req), 32'd0);
        chk("freeze_pc", instr_pc, 32'd12);
        step(0, 0, 0, 1);
        chk("drain_order", instr_pc, 32'd16);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Branch while a fetch waits: old address held, data dropped.
        step(0, 0, 0, 0);
        held = imem_bus.addr;
        step(0, 1, 32'h100, 0);
        chk("drop_flush", 32'(flush), 32'd1);
        chk("drop_hold", imem_bus.addr, held);
        chk("drop_empty", 32'(instr_valid), 32'd0);
        step(0, 0, 0, 0);
        chk("flush_once", 32'(flush), 32'd0);
        chk("drop_hold2", imem_bus.addr, held);
        step(0, 0, 0, 1);
        chk("redirect_addr", imem_bus.addr, 32'h100);
        chk("redirect_empty", 32'(instr_valid), 32'd0);

        // Branch coinciding with ready and pop.
        step(0, 0, 0, 1);
        step(0, 1, 32'h40, 1);
        chk("br_ready_addr", imem_bus.addr, 32'h40);
        chk("br_ready_empty", 32'(instr_valid), 32'd0);

        // PC wrap.
        step(0, 1, 32'hFFFF_FFF8, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("wrap_addr", imem_bus.addr, 32'd0);

        // Ready withheld beyond the timeout.
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0);
        chk("timeout_err", 32'(fetch_err), 32'(TO_EN));
        step(0, 0, 0, 1);
        chk("timeout_sticky", 32'(fetch_err), 32'(TO_EN));

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            ba = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, ba,
                 $urandom_range(0, 9) < 6);
        end

        // Asynchronous reset in the middle of a transaction.
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_req", 32'(imem_bus.req), 32'd0);
        chk("mid_rst_addr", imem_bus.addr, RST_PC);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_flush", 32'(flush), 32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        chk("mid_rst_err", 32'(fetch_err), 32'd0);
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) < 6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
